// File: rtl/fetch_pkg.sv
// Constants shared between the fetch queue and the fusion decoder.
package fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RV_NOP    = 32'h0000_0013;
    localparam logic [6:0]  OPC_LUI   = 7'b0110111;
    localparam logic [6:0]  OPC_OPIMM = 7'b0010011;

endpackage : fetch_pkg

// File: rtl/fetch_pair_queue.sv
// Instruction queue feeding fusion_decoder: presents the two oldest entries
// and retires one, or two on a reported fusion.
module fetch_pair_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = fetch_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out0_valid,
    output logic [XLEN-1:0]            out0_inst,
    output logic [XLEN-1:0]            out0_pc,
    output logic                       out1_valid,
    output logic [XLEN-1:0]            out1_inst,
    output logic [XLEN-1:0]            out1_pc,
    input  logic                       dec_ready,
    input  logic                       fuse_flag,
    output logic [$clog2(DEPTH):0]     count
);
    import fetch_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] inst_q [DEPTH];
    logic [XLEN-1:0] inst_d [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] pc_d   [DEPTH];

    logic            push;
    logic [1:0]      pop;
    logic [PW-1:0]   rd_ptr_p1;

    // Handshake and pop decision from registered occupancy only.
    always_comb begin
        in_ready   = (cnt_q < CW'(DEPTH)) && !flush;
        push       = in_valid && in_ready;
        out0_valid = (cnt_q >= CW'(1));
        out1_valid = (cnt_q >= CW'(2));
        pop        = 2'd0;
        if (dec_ready && out0_valid) begin
            pop = (fuse_flag && out1_valid) ? 2'd2 : 2'd1;
        end
    end

    // Head pair read; invalid slots show a NOP so stale data can never fuse.
    always_comb begin
        rd_ptr_p1 = rd_ptr_q + PW'(1);
        out0_inst = RV_NOP[XLEN-1:0];
        out0_pc   = '0;
        out1_inst = RV_NOP[XLEN-1:0];
        out1_pc   = '0;
        if (out0_valid) begin
            out0_inst = inst_q[rd_ptr_q];
            out0_pc   = pc_q[rd_ptr_q];
        end
        if (out1_valid) begin
            out1_inst = inst_q[rd_ptr_p1];
            out1_pc   = pc_q[rd_ptr_p1];
        end
        count = cnt_q;
    end

    // Next-state: flush overrides push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                inst_d[wr_ptr_q] = in_inst;
                pc_d[wr_ptr_q]   = in_pc;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            rd_ptr_d = rd_ptr_q + PW'(pop);
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
        end
    end

endmodule : fetch_pair_queue
